// File: rtl/xnor_neuron_acc.sv
// ---------------------------------------------------------------------------
// xnor_neuron_acc
//   Binary-neuron accumulator for the Binary-MLP datapath.
//   Each accepted beat computes an XNOR-popcount of in_x against in_w and
//   turns it into a signed partial sum ps = 2*popcount - WORD_W.
//   The partial sum is added into a 15-bit two's-complement accumulator using
//   the adder_15b rule (Cin=0, overflow when the operand signs agree but the
//   result sign differs).
//   After NUM_BEATS beats the pre-activation sum, the binary activation and a
//   sticky overflow flag are presented on a valid/ready output.
//
// Parameters
//   WORD_W     bits of x/w per beat (power of 2, 2..256)
//   NUM_BEATS  beats per neuron (>=1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   beat valid
//   in_ready   beat accept (depends on state only)
//   in_x       binary activations, 1=+1 / 0=-1
//   in_w       binary weights, same encoding
//   bias       signed bias, sampled on the first beat of a neuron only
//   out_valid  result valid
//   out_ready  result accept
//   out_sum    signed accumulated sum
//   out_act    binary activation, 1 when out_sum >= 0
//   out_ovf    sticky overflow over all adds of the neuron
//
// Configuration macro
//   ACC_SATURATE_EN  defined: an overflowing add clamps to +16383 / -16384
//                    undefined: the accumulator wraps modulo 2^15
// ---------------------------------------------------------------------------
module xnor_neuron_acc #(
  parameter int WORD_W    = 32,
  parameter int NUM_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_x,
  input  logic [WORD_W-1:0] in_w,
  input  logic [14:0]       bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       out_sum,
  output logic              out_act,
  output logic              out_ovf
);

  localparam int                CNT_W    = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_BEATS - 1);
  localparam logic [14:0]       SAT_POS  = 15'h3FFF;
  localparam logic [14:0]       SAT_NEG  = 15'h4000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [14:0]      r_acc;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_ovf_acc;
  logic             r_out_valid;
  logic [14:0]      r_out_sum;
  logic             r_out_act;
  logic             r_out_ovf;

  logic [WORD_W-1:0] w_match;
  logic [14:0]       w_pop;
  logic [14:0]       w_ps;
  logic [14:0]       w_add_a;
  logic [14:0]       w_add_sum;
  logic              w_add_ovf;
  logic [14:0]       w_add_res;
  logic              w_ovf_next;
  logic              w_last;
  logic              w_beat_acc;

  // Positions where activation and weight agree contribute +1, others -1.
  assign w_match = ~(in_x ^ in_w);

  // Partial sum in 15-bit two's complement; |ps| <= 256 so it always fits,
  // which makes the modular subtraction equal to the sign-extended value.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      w_pop = w_pop + 15'(w_match[i]);
    end
    w_ps = (w_pop << 1) - 15'(WORD_W);
  end

  // The first beat of a neuron adds into the bias instead of the accumulator.
  assign w_add_a   = (r_state == S_IDLE) ? bias : r_acc;
  assign w_add_sum = w_add_a + w_ps;
  assign w_add_ovf = (w_add_a[14] == w_ps[14]) && (w_add_sum[14] != w_add_a[14]);

`ifdef ACC_SATURATE_EN
  // Clamp toward the common sign of the operands.
  always_comb begin
    w_add_res = w_add_sum;
    if (w_add_ovf) begin
      w_add_res = w_add_a[14] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign w_add_res = w_add_sum;
`endif

  assign w_ovf_next = ((r_state == S_IDLE) ? 1'b0 : r_ovf_acc) | w_add_ovf;

  // beat_cnt is 0 in IDLE, so this single compare also covers NUM_BEATS==1.
  assign w_last     = (r_beat_cnt == LAST_CNT);
  assign w_beat_acc = in_valid && (r_state != S_DONE);

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_act   = r_out_act;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_act   <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_beat_acc) begin
            r_acc      <= w_add_res;
            r_ovf_acc  <= w_ovf_next;
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_add_res;
              r_out_act   <= ~w_add_res[14];
              r_out_ovf   <= w_ovf_next;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_ovf_acc   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_neuron_acc.sv
module tb_xnor_neuron_acc;

  localparam int NB = 4;
  typedef logic [31:0] word_arr_t [NB];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_w;
  logic [14:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_sum;
  logic        out_act;
  logic        out_ovf;

  always #5 clk = ~clk;

  xnor_neuron_acc #(.WORD_W(32), .NUM_BEATS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_act   (out_act),
    .out_ovf   (out_ovf)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Neuron model: integer arithmetic on the true sum, then range check.
  function automatic void model(input int b, input word_arr_t xs, input word_arr_t ws,
                                output int s, output bit ovf);
    int acc;
    int t;
    acc = b;
    ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      t = acc + 2 * $countones(~(xs[i] ^ ws[i])) - 32;
      if (t > 16383 || t < -16384) begin
        ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        t = (t > 0) ? 16383 : -16384;
`else
        t = (t > 0) ? t - 32768 : t + 32768;
`endif
      end
      acc = t;
    end
    s = acc;
  endfunction

  // Monitor / scoreboard state
  word_arr_t mx, mw;
  int  mcnt = 0;
  int  mbias = 0;
  int  exp_sum[$];
  bit  exp_ovf[$];
  int  n_results = 0;
  int  cap_sum = 0, cap_act = 0, cap_ovf = 0;
  bit  chk_valid_next = 1'b0;
  bit  chk_ready_next = 1'b0;

  always @(negedge clk) begin
    int s;
    bit o;
    if (!rst_n) begin
      mcnt = 0;
      chk_valid_next = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      if (chk_valid_next) begin
        check("latency_out_valid", out_valid, 1);
        chk_valid_next = 1'b0;
      end
      if (chk_ready_next) begin
        check("in_ready_after_handshake", in_ready, 1);
        chk_ready_next = 1'b0;
      end
      if (out_valid) begin
        if (exp_sum.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          check("out_sum", int'($signed(out_sum)), exp_sum[0]);
          check("out_act", out_act, int'(exp_sum[0] >= 0));
          check("out_ovf", out_ovf, int'(exp_ovf[0]));
          check("in_ready_while_done", in_ready, 0);
          if (out_ready) begin
            cap_sum = int'($signed(out_sum));
            cap_act = out_act;
            cap_ovf = out_ovf;
            void'(exp_sum.pop_front());
            void'(exp_ovf.pop_front());
            n_results++;
            chk_ready_next = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (mcnt == 0) mbias = int'($signed(bias));
        mx[mcnt] = in_x;
        mw[mcnt] = in_w;
        mcnt++;
        if (mcnt == NB) begin
          model(mbias, mx, mw, s, o);
          exp_sum.push_back(s);
          exp_ovf.push_back(o);
          mcnt = 0;
          chk_valid_next = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
  endtask

  // Beats after the first carry a junk bias that must be ignored.
  task automatic send_neuron(input logic [14:0] b, input word_arr_t xs, input word_arr_t ws,
                             input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_x     = xs[i];
      in_w     = ws[i];
      bias     = (i == 0) ? b : 15'h2AAA;
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_result(input int target);
    int t = 0;
    while (n_results < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("result_count", n_results, target);
  endtask

  task automatic pin_model(input string name, input int b, input word_arr_t xs,
                           input word_arr_t ws, input int es, input int eo);
    int s;
    bit o;
    model(b, xs, ws, s, o);
    check({name, "_model_sum"}, s, es);
    check({name, "_model_ovf"}, int'(o), eo);
  endtask

  task automatic pin_dut(input string name, input int es, input int ea, input int eo);
    check({name, "_sum"}, cap_sum, es);
    check({name, "_act"}, cap_act, ea);
    check({name, "_ovf"}, cap_ovf, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_arr_t xa, wa, xb, x0, wf, x7, w7;
    int t;
    xa = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    xb = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A};
    x0 = '{32'h0, 32'h0, 32'h0, 32'h0};
    wf = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
    x7 = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h00000000};
    w7 = '{32'hDEADBEEF, 32'h87654321, 32'h00000000, 32'h00000000};
    wa = xa;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_act", out_act, 0);
    check("reset_out_ovf", out_ovf, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: x == w, ps=+32 per beat
    pin_model("T1", 0, xa, wa, 128, 0);
    send_neuron(15'd0, xa, wa, NB, 1'b0);
    wait_result(1);
    pin_dut("T1", 128, 1, 0);

    // T2: x == ~w, ps=-32 per beat
    pin_model("T2", 10, xb, wa, -118, 0);
    send_neuron(15'd10, xb, wa, NB, 1'b0);
    wait_result(2);
    pin_dut("T2", -118, 0, 0);

    // T3: half the bits agree, ps=0; zero sum gives act=1
    pin_model("T3", 0, x0, wf, 0, 0);
    send_neuron(15'd0, x0, wf, NB, 1'b0);
    wait_result(3);
    pin_dut("T3", 0, 1, 0);

    // T4: positive overflow
`ifdef ACC_SATURATE_EN
    pin_model("T4", 16380, xa, wa, 16383, 1);
    send_neuron(15'd16380, xa, wa, NB, 1'b0);
    wait_result(4);
    pin_dut("T4", 16383, 1, 1);
`else
    pin_model("T4", 16380, xa, wa, -16260, 1);
    send_neuron(15'd16380, xa, wa, NB, 1'b0);
    wait_result(4);
    pin_dut("T4", -16260, 0, 1);
`endif

    // T5: in_valid gaps and output backpressure
    out_ready = 1'b0;
    send_neuron(15'd0, xa, wa, NB, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("T5_out_valid_seen", out_valid, 1);
    repeat (5) @(negedge clk);
    check("T5_still_valid", out_valid, 1);
    check("T5_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_result(5);
    pin_dut("T5", 128, 1, 0);

    // T6: reset after two beats discards the partial neuron
    send_neuron(15'd0, xa, wa, 2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("T6_out_valid", out_valid, 0);
    check("T6_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send_neuron(15'd0, xa, wa, NB, 1'b0);
    wait_result(6);
    pin_dut("T6", 128, 1, 0);

    // T7: distinct words per beat, negative bias: -5+32+4-32+32
    pin_model("T7", -5, x7, w7, 31, 0);
    send_neuron(15'h7FFB, x7, w7, NB, 1'b0);
    wait_result(7);
    pin_dut("T7", 31, 1, 0);

    // T8: negative overflow
`ifdef ACC_SATURATE_EN
    pin_model("T8", -16380, xb, wa, -16384, 1);
    send_neuron(15'h4004, xb, wa, NB, 1'b0);
    wait_result(8);
    pin_dut("T8", -16384, 0, 1);
`else
    pin_model("T8", -16380, xb, wa, 16260, 1);
    send_neuron(15'h4004, xb, wa, NB, 1'b0);
    wait_result(8);
    pin_dut("T8", 16260, 1, 1);
`endif

    // Overflow must not leak into the next neuron.
    send_neuron(15'd0, xa, wa, NB, 1'b0);
    wait_result(9);
    pin_dut("T9", 128, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_sum.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
